// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B) writeback.
// One-cycle registered write stage; combinational grants; no downstream back-pressure.
module reg_write_arbiter #(
   parameter int n = 32,
   parameter int r = 7
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         aValid,
   input  logic [r-1:0] aReg,
   input  logic [n-1:0] aData,
   output logic         aReady,
   input  logic         bValid,
   input  logic [r-1:0] bReg,
   input  logic [n-1:0] bData,
   output logic         bReady,
   output logic         writeEnable,
   output logic [r-1:0] writeReg,
   output logic [n-1:0] writeData,
   input  logic [r-1:0] queryReg1,
   input  logic [r-1:0] queryReg2,
   output logic         hazard1,
   output logic         hazard2
);

   typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} side_t;

   side_t         last_grant_q, last_grant_d;
   logic          we_q, we_d;
   logic [r-1:0]  wreg_q, wreg_d;
   logic [n-1:0]  wdat_q, wdat_d;
   logic          grant_a, grant_b;
   logic [r-1:0]  win_reg;
   logic [n-1:0]  win_dat;

   // A wins unless B is also valid and A took the previous grant.
   always_comb begin
      grant_a = aValid && (!bValid || (last_grant_q == GRANT_B));
      grant_b = bValid && !grant_a;
   end

   always_comb begin
      win_reg      = grant_a ? aReg  : bReg;
      win_dat      = grant_a ? aData : bData;
      last_grant_d = last_grant_q;
      we_d         = 1'b0;
      wreg_d       = wreg_q;
      wdat_d       = wdat_q;
      if (grant_a || grant_b) begin
         last_grant_d = grant_a ? GRANT_A : GRANT_B;
         // Writes to register 0 complete the handshake but never reach the file.
         if (win_reg != '0) begin
            we_d   = 1'b1;
            wreg_d = win_reg;
            wdat_d = win_dat;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= GRANT_B;
         we_q         <= 1'b0;
         wreg_q       <= '0;
         wdat_q       <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         wreg_q       <= wreg_d;
         wdat_q       <= wdat_d;
      end
   end

   function automatic logic hazard_for(input logic [r-1:0] q);
      return (q != '0) &&
             ((we_q && (wreg_q == q)) ||
              (aValid && (aReg == q)) ||
              (bValid && (bReg == q)));
   endfunction

   assign aReady      = grant_a;
   assign bReady      = grant_b;
   assign writeEnable = we_q;
   assign writeReg    = wreg_q;
   assign writeData   = wdat_q;
   assign hazard1     = hazard_for(queryReg1);
   assign hazard2     = hazard_for(queryReg2);

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares the single write port of the register file between two writeback requesters: A (ALU result) and B (memory load). The block arbitrates round-robin, registers the winning write onto the register file's `writeEnable`/`writeReg`/`writeData` inputs, drops writes to register 0, and reports read-after-write hazards to the decode stage. It sits between the execute/memory stages and the register file.

## Interface
Parameters:
- `n`, 32, data width; must match the register file.
- `r`, 7, register index width (2**r registers).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `aValid`  in  1  requester A has a write pending.
- `aReg`  in  r  A destination register.
- `aData`  in  n  A write data.
- `aReady`  out  1  A grant; A's write is accepted on a rising edge where `aValid && aReady`.
- `bValid`, `bReg`, `bData`, `bReady`: same as A, for requester B.
- `writeEnable`  out  1  to register file.
- `writeReg`  out  r  to register file.
- `writeData`  out  n  to register file.
- `queryReg1`, `queryReg2`  in  r  source registers being decoded.
- `hazard1`, `hazard2`  out  1  a pending or in-flight write targets the queried register.

## Operation
- State:
  - `lastGrant` (1 bit: A or B).
  - Output stage: `writeEnable`, `writeReg`, `writeData`.
- Arbitration (combinational from current state and valids):
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the side that is not `lastGrant`.
  - Neither valid: no grant.
  - `aReady`/`bReady` are high only for the granted side. At most one is high per cycle. Neither is ever high while its valid is low.
- On each rising edge with a grant to side X:
  - `lastGrant <= X`.
  - If `XReg != 0`: `writeEnable <= 1`, `writeReg <= XReg`, `writeData <= XData`.
  - If `XReg == 0`: the handshake completes and `writeEnable <= 0`. The write is silently dropped, and the `writeReg`/`writeData` outputs hold their old values.
- On a rising edge with no grant:
  - `writeEnable <= 0`; `writeReg`/`writeData` hold.
  - `lastGrant` holds.
- The register file always accepts, so there is no back-pressure from downstream. The output stage drains every cycle.
- Hazard, for each query q in {1, 2}:
  - hazardq = (queryRegq != 0) && ((writeEnable && writeReg == queryRegq) || (aValid && aReg == queryRegq) || (bValid && bReg == queryRegq)).
  - Purely combinational. Register 0 never produces a hazard.
- Same destination from A and B in the same cycle:
  - Both are written, in grant order.
  - The later grant's data is the final register value.

## Timing
- Reset (asynchronous assert, released synchronously by the system):
  - `writeEnable = 0`, `writeReg = 0`, `writeData = 0`.
  - `lastGrant = B`, so A wins the first contested cycle.
  - `aReady`/`bReady` follow the arbitration equations from the reset state. `hazard1`/`hazard2` depend only on inputs once `writeEnable` is cleared.
- Reset asserted mid-operation:
  - The output stage clears immediately; a write in the output stage is lost, not committed.
  - Requesters must re-present any request that was not yet handshaken.
- Latency:
  - Request accepted at edge k.
  - `writeEnable` high during cycle k..k+1.
  - Register file commits at edge k+1.
  - Value is visible on the register file's falling-edge read in cycle k+1.
- Throughput: one write per cycle. With both requesters continuously valid, grants strictly alternate A, B, A, B. Neither side waits more than one cycle.
- `aReady`/`bReady` are combinational on the valids. Requesters must not make valid depend on ready.
- A requester that holds valid must keep `Reg`/`Data` stable until its handshake.

## Test plan
- Reset, then A alone writes reg 5 = 0xDEADBEEF -> `aReady` = 1 in that cycle; next cycle `writeEnable` = 1, `writeReg` = 5, `writeData` = 0xDEADBEEF. A register-file read of reg 5 returns 0xDEADBEEF.
- A and B both continuously valid for 6 cycles from reset -> grant sequence A, B, A, B, A, B. `writeEnable` is high on 6 consecutive cycles with matching reg/data.
- A writes reg 0 = 0x12345678 -> handshake completes; `writeEnable` stays 0 the following cycle; reg 0 is unchanged.
- Same cycle: A writes reg 9 = 0x1, B writes reg 9 = 0x2, with `lastGrant` = B -> A then B are committed; reg 9 ends at 0x2.
- `queryReg1` = 9 while B is valid to reg 9, then while reg 9 sits in the output stage, then one cycle later -> `hazard1` = 1, 1, 0. `queryReg2` = 0 with any traffic -> `hazard2` = 0.
- `reset` asserted mid-cycle while the output stage holds a write to reg 3 -> `writeEnable` drops to 0 immediately with no clock edge; reg 3 is not written; the first contested grant after reset goes to A.
